// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller: ALU op codes, RV32I opcodes,
// FSM states and operand-select enums.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_NOT   = 4'b0010,
    ALU_AND   = 4'b0011,
    ALU_OR    = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SLT   = 4'b0110,
    ALU_EQU   = 4'b0111,
    ALU_SLL   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_SRL   = 4'b1010,
    ALU_SRA   = 4'b1011,
    ALU_LUI   = 4'b1100,
    ALU_AUIPC = 4'b1101
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_WB} state_t;
  typedef enum logic {A_ZERO, A_RS1} a_sel_t;
  typedef enum logic {B_IMM, B_RS2} b_sel_t;

  // alt selects SUB for funct3 000 and SRA for funct3 101; ignored elsewhere
  function automatic alu_op_t f3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in and write-back handshake bundle of the ALU issue controller.
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        illegal;

  modport master (
    output in_valid, in_instr, in_pc, wb_ready,
    input  in_ready, wb_valid, wb_rd, wb_we, wb_data, illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, wb_ready,
    output in_ready, wb_valid, wb_rd, wb_we, wb_data, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational RV32I decode of the ALU-class instructions into ALU op code,
// operand selects, immediate and destination register.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_t     ctrl,
  output a_sel_t      a_sel,
  output b_sel_t      b_sel,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] f3;
  logic       is_shift;

  assign opcode   = instr[6:0];
  assign funct7   = instr[31:25];
  assign f3       = instr[14:12];
  assign rd       = instr[11:7];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    ctrl    = ALU_ADD;
    a_sel   = A_ZERO;
    b_sel   = B_IMM;
    imm     = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_sel   = A_RS1;
        b_sel   = B_RS2;
        ctrl    = f3_to_op(f3, instr[30]);
        illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end
      OPC_OP_IMM: begin
        a_sel = A_RS1;
        if (is_shift) begin
          imm     = {27'b0, instr[24:20]};
          ctrl    = f3_to_op(f3, instr[30]);
          illegal = !((funct7 == F7_BASE) || ((funct7 == F7_ALT) && (f3 == 3'b101)));
        end else begin
          // ADDI never becomes SUB even though bit 30 belongs to the immediate
          imm  = {{20{instr[31]}}, instr[31:20]};
          ctrl = f3_to_op(f3, 1'b0);
        end
      end
      OPC_LUI: begin
        ctrl = ALU_LUI;
        imm  = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        ctrl = ALU_AUIPC;
        imm  = {instr[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the registered ALU: accepts one instruction,
// drives the ALU operands, waits the fixed result latency, then emits a write-back beat.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int RESULT_WAIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_ctrl_if.slave     bus,
  output logic [4:0]          rs1_addr,
  input  logic [31:0]         rs1_data,
  output logic [4:0]          rs2_addr,
  input  logic [31:0]         rs2_data,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  output logic [3:0]          alu_ctrl,
  output logic [31:0]         alu_pc,
  output logic                tick_idex,
  input  logic [31:0]         alu_result_in
);

  localparam int              CNT_W    = $clog2(RESULT_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESULT_WAIT);

  alu_op_t     dec_ctrl;
  a_sel_t      dec_a_sel;
  b_sel_t      dec_b_sel;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rd;
  logic        dec_illegal;

  alu_decode u_decode (
    .instr   (bus.in_instr),
    .ctrl    (dec_ctrl),
    .a_sel   (dec_a_sel),
    .b_sel   (dec_b_sel),
    .imm     (dec_imm),
    .rd      (dec_rd),
    .illegal (dec_illegal)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  alu_op_t          ctrl_q, ctrl_d;
  a_sel_t           a_sel_q, a_sel_d;
  b_sel_t           b_sel_q, b_sel_d;
  logic [31:0]      imm_q, imm_d;
  logic [31:0]      pc_q, pc_d;
  logic [4:0]       rs1_addr_q, rs1_addr_d;
  logic [4:0]       rs2_addr_q, rs2_addr_d;
  logic [31:0]      rs1_val_q, rs1_val_d;
  logic [31:0]      rs2_val_q, rs2_val_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_we_q, wb_we_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             illegal_q, illegal_d;

  logic accept;
  assign accept = (state_q == ST_IDLE) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && !dec_illegal) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (wait_cnt_q == CNT_LAST) state_d = ST_WB;
      ST_WB:    if (bus.wb_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    ctrl_d     = ctrl_q;
    a_sel_d    = a_sel_q;
    b_sel_d    = b_sel_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rs1_val_d  = rs1_val_q;
    rs2_val_d  = rs2_val_q;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    wb_data_d  = wb_data_q;
    illegal_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        illegal_d = dec_illegal;
        if (!dec_illegal) begin
          ctrl_d     = dec_ctrl;
          a_sel_d    = dec_a_sel;
          b_sel_d    = dec_b_sel;
          imm_d      = dec_imm;
          pc_d       = bus.in_pc;
          rs1_addr_d = bus.in_instr[19:15];
          rs2_addr_d = bus.in_instr[24:20];
          wb_rd_d    = dec_rd;
          wb_we_d    = (dec_rd != 5'd0);
        end
      end
      ST_ISSUE: begin
        // the regfile is combinational, so its data is valid only now; keep a copy
        rs1_val_d  = rs1_data;
        rs2_val_d  = rs2_data;
        wait_cnt_d = CNT_W'(1);
      end
      ST_WAIT: begin
        if (wait_cnt_q == CNT_LAST) wb_data_d = alu_result_in;
        else                        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      ctrl_q     <= ALU_ADD;
      a_sel_q    <= A_ZERO;
      b_sel_q    <= B_IMM;
      imm_q      <= '0;
      pc_q       <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      ctrl_q     <= ctrl_d;
      a_sel_q    <= a_sel_d;
      b_sel_q    <= b_sel_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rs1_val_q  <= rs1_val_d;
      rs2_val_q  <= rs2_val_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
    end
  end

  logic [31:0] rs1_op, rs2_op;

  always_comb begin
    // during ISSUE pass the live regfile data, afterwards the captured copy
    rs1_op        = (state_q == ST_ISSUE) ? rs1_data : rs1_val_q;
    rs2_op        = (state_q == ST_ISSUE) ? rs2_data : rs2_val_q;
    alu_a         = (a_sel_q == A_RS1) ? rs1_op : 32'd0;
    alu_b         = (b_sel_q == B_RS2) ? rs2_op : imm_q;
    alu_ctrl      = ctrl_q;
    alu_pc        = pc_q;
    rs1_addr      = rs1_addr_q;
    rs2_addr      = rs2_addr_q;
    tick_idex     = (state_q == ST_ISSUE);
    bus.in_ready  = (state_q == ST_IDLE);
    bus.wb_valid  = (state_q == ST_WB);
    bus.wb_rd     = wb_rd_q;
    bus.wb_we     = wb_we_q;
    bus.wb_data   = wb_data_q;
    bus.illegal   = illegal_q;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed instructions push expectations,
// a negedge monitor checks ALU issue, write-back beats and illegal pulses.
module tb_alu_issue_ctrl;

  localparam logic [31:0] RES_BASE = 32'hA500_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus();

  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] alu_a, alu_b, alu_pc, alu_result_in;
  logic [3:0]  alu_ctrl;
  logic        tick_idex;
  logic [31:0] regs [32];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // result changes every cycle so the sampling instant is observable
  assign alu_result_in = RES_BASE + 32'(cyc);
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  alu_issue_ctrl #(.RESULT_WAIT(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .rs1_addr      (rs1_addr),
    .rs1_data      (rs1_data),
    .rs2_addr      (rs2_addr),
    .rs2_data      (rs2_data),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_ctrl      (alu_ctrl),
    .alu_pc        (alu_pc),
    .tick_idex     (tick_idex),
    .alu_result_in (alu_result_in)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic        chk_pc;
    logic [4:0]  rd;
    logic        we;
    int          acc;
    logic        ticked;
  } exp_t;

  exp_t sb[$];
  int   ill_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic wb_started = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flag(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
  endfunction

  // ---------------- monitor ----------------
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (tick_idex) begin
        if (sb.size() == 0 || sb[0].ticked) flag("unexpected_tick");
        else begin
          e = sb[0];
          chk("tick_cycle", 32'(cyc), 32'(e.acc + 1));
          chk("alu_ctrl", 32'(alu_ctrl), 32'(e.ctrl));
          chk("alu_a", alu_a, e.a);
          chk("alu_b", alu_b, e.b);
          if (e.chk_pc) chk("alu_pc", alu_pc, e.pc);
          chk("rs1_addr", 32'(rs1_addr), 32'(e.instr[19:15]));
          chk("rs2_addr", 32'(rs2_addr), 32'(e.instr[24:20]));
          sb[0].ticked = 1'b1;
          $display("issue  instr=%08h ctrl=%0h a=%08h b=%08h", e.instr, alu_ctrl, alu_a, alu_b);
        end
      end
      if (bus.wb_valid) begin
        if (sb.size() == 0) flag("unexpected_wb");
        else begin
          e = sb[0];
          if (!wb_started) begin
            chk("wb_latency", 32'(cyc), 32'(e.acc + 5));
            wb_started = 1'b1;
          end
          chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
          chk("wb_we", 32'(bus.wb_we), 32'(e.we));
          chk("wb_data", bus.wb_data, RES_BASE + 32'(e.acc + 4));
          chk("in_ready_in_wb", 32'(bus.in_ready), 32'd0);
          if (bus.wb_ready) begin
            chk("held_ctrl", 32'(alu_ctrl), 32'(e.ctrl));
            chk("held_a", alu_a, e.a);
            chk("held_b", alu_b, e.b);
            $display("wb     instr=%08h rd=%0d we=%0b data=%08h", e.instr, bus.wb_rd, bus.wb_we, bus.wb_data);
            void'(sb.pop_front());
            wb_started = 1'b0;
          end
        end
      end
      if (bus.illegal) begin
        if (ill_q.size() == 0) flag("unexpected_illegal");
        else begin
          chk("illegal_cycle", 32'(cyc), 32'(ill_q.pop_front()));
          chk("illegal_in_ready", 32'(bus.in_ready), 32'd1);
          $display("illegal pulse at cycle %0d", cyc);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [3:0] ctrl,
                       input logic [31:0] a, input logic [31:0] b, input logic chk_pc,
                       input logic [4:0] rd, input logic we, input logic bad);
    int w = 0;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.in_ready) flag("accept_timeout");
    else if (bad) ill_q.push_back(cyc + 1);
    else sb.push_back('{instr, ctrl, a, b, pc, chk_pc, rd, we, cyc, 1'b0});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
  endtask

  task automatic drain(input int stall);
    int w = 0;
    if (stall > 0) begin
      while (!bus.wb_valid && w < 40) begin
        @(posedge clk); #1;
        w++;
      end
      bus.wb_ready = 1'b0;
      repeat (stall) @(posedge clk);
      #1;
      bus.wb_ready = 1'b1;
    end
    w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_done", 32'(sb.size()), 32'd0);
  endtask

  task automatic run(input logic [31:0] instr, input logic [31:0] pc, input logic [3:0] ctrl,
                     input logic [31:0] a, input logic [31:0] b, input logic chk_pc,
                     input logic [4:0] rd, input logic we, input int stall);
    issue(instr, pc, ctrl, a, b, chk_pc, rd, we, 1'b0);
    drain(stall);
  endtask

  task automatic run_bad(input logic [31:0] instr);
    issue(instr, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("illegal_seen", 32'(ill_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
    regs[0] = 32'd0;
    regs[1] = 32'd10;
    regs[2] = 32'd3;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc    = '0;
    bus.wb_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_tick", 32'(tick_idex), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_alu_pc", alu_pc, 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_rs_addr", 32'({rs1_addr, rs2_addr}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    //   instr          pc            ctrl   a             b             pc?   rd     we    stall
    run(32'h00700293, 32'h0000_0000, 4'h0, 32'd0,        32'd7,        1'b0, 5'd5,  1'b1, 0); // ADDI x5,x0,7
    run(32'h402081B3, 32'h0000_0004, 4'h1, 32'd10,       32'd3,        1'b0, 5'd3,  1'b1, 0); // SUB x3,x1,x2
    run(32'h4040D093, 32'h0000_0008, 4'hB, 32'd10,       32'd4,        1'b0, 5'd1,  1'b1, 0); // SRAI x1,x1,4
    run(32'h123453B7, 32'h0000_000C, 4'hC, 32'd0,        32'h12345000, 1'b0, 5'd7,  1'b1, 0); // LUI x7,0x12345
    run(32'h00001417, 32'h0000_0100, 4'hD, 32'd0,        32'h00001000, 1'b1, 5'd8,  1'b1, 0); // AUIPC x8,1
    run(32'hFFF10313, 32'h0000_0104, 4'h0, 32'd3,        32'hFFFFFFFF, 1'b0, 5'd6,  1'b1, 0); // ADDI x6,x2,-1
    run(32'h00513513, 32'h0000_0108, 4'h9, 32'd3,        32'd5,        1'b0, 5'd10, 1'b1, 0); // SLTIU x10,x2,5
    run(32'h0020D5B3, 32'h0000_010C, 4'hA, 32'd10,       32'd3,        1'b0, 5'd11, 1'b1, 0); // SRL x11,x1,x2
    run(32'h00208033, 32'h0000_0110, 4'h0, 32'd10,       32'd3,        1'b0, 5'd0,  1'b0, 3); // ADD x0, stalled

    run_bad(32'h0000007F); // unknown opcode
    run_bad(32'h02208033); // R-type funct7 0000001
    run_bad(32'h40409093); // SLLI with funct7 0100000

    // reset while waiting for the ALU result: instruction is dropped
    issue(32'h0020C233, 32'h0000_0200, 4'h5, 32'd10, 32'd3, 1'b0, 5'd4, 1'b1, 1'b0); // XOR x4,x1,x2
    @(posedge clk); #1;
    rst = 1'b1;
    if (sb.size() > 0) void'(sb.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("midrst_tick", 32'(tick_idex), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    run(32'h0020E4B3, 32'h0000_0204, 4'h4, 32'd10, 32'd3, 1'b0, 5'd9, 1'b1, 0); // OR x9,x1,x2

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
